i2c_xfer_ctrl: RTL and testbench



---
 rtl/i2c_xfer_ctrl_pkg.sv | 22 ++
 rtl/i2c_fifo.sv | 56 +++++
 rtl/i2c_xfer_ctrl.sv | 162 ++++++++++++++++
 tb/tb_i2c_xfer_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_xfer_ctrl_pkg.sv
// Shared definitions for the I2C transaction front end: field widths,
// controller state encoding and the command length clamp.
package i2c_defs;

    localparam int DEV_W = 7;
    localparam int REG_W = 8;
    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_TX = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE    = 3'd4
    } xfer_state_t;

    // A zero-length command still moves one byte.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

endpackage

// File: rtl/i2c_fifo.sv
// Synchronous first-word-fall-through byte FIFO with a second read port
// exposing the entry behind the head, used for zero-latency lookahead.
module i2c_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          push,
    input  logic [7:0]    push_dat,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [7:0]    head_nxt,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] rd_idx_nxt;
    logic          do_push;
    logic          do_pop;

    assign level      = wr_ptr_reg - rd_ptr_reg;
    assign empty      = (level == '0);
    assign full       = level[AW];
    assign rd_idx     = rd_ptr_reg[AW-1:0];
    assign rd_idx_nxt = rd_idx + 1'b1;

    // A push into a full FIFO is honoured only when a pop frees the slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Unoccupied slots read as zero so stale bytes never leak out.
    assign head     = empty ? 8'h00 : mem[rd_idx];
    assign head_nxt = (level > (AW+1)'(1)) ? mem[rd_idx_nxt] : 8'h00;

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/i2c_xfer_ctrl.sv
// Transaction front end for the byte-level I2C master: takes one command at a
// time, buffers TX/RX bytes and reports completion and early termination.
module i2c_xfer_ctrl
    import i2c_defs::*;
#(
    parameter int TX_AW = 4,
    parameter int RX_AW = 4
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_rw_i,
    input  logic               cmd_ur_i,
    input  logic [DEV_W-1:0]   cmd_devadr_i,
    input  logic [REG_W-1:0]   cmd_regadr_i,
    input  logic [LEN_W-1:0]   cmd_len_i,
    input  logic               tx_wr_i,
    input  logic [7:0]         tx_dat_i,
    output logic               tx_full_o,
    output logic [TX_AW:0]     tx_level_o,
    input  logic               rx_rd_i,
    output logic [7:0]         rx_dat_o,
    output logic               rx_empty_o,
    output logic               done_o,
    output logic               nack_o,
    output logic               tx_unf_o,
    output logic               rx_ovf_o,
    output logic               m_enable_o,
    output logic               m_rw_o,
    output logic               m_ur_o,
    output logic [DEV_W-1:0]   m_devadr_o,
    output logic [REG_W-1:0]   m_regadr_o,
    output logic [LEN_W-1:0]   m_datnum_o,
    output logic [7:0]         m_dat_o,
    input  logic [7:0]         m_dat_i,
    input  logic               m_busy_i,
    input  logic               m_dvalid_i,
    input  logic               m_newdat_i
);

    localparam logic [LEN_W-1:0] TX_DEPTH_L = LEN_W'(1 << TX_AW);

    xfer_state_t       state_reg;
    xfer_state_t       state_next;
    logic [LEN_W:0]    byte_cnt_reg;
    logic              nack_reg;
    logic              unf_reg;
    logic              ovf_reg;
    logic              accept;
    logic              tx_ok;
    logic [LEN_W-1:0]  tx_need;

    logic [7:0]        tx_head;
    logic [7:0]        tx_head_nxt;
    logic              tx_empty;
    logic              rx_full;
    logic [7:0]        rx_head_nxt_unused;
    logic [RX_AW:0]    rx_level_unused;

    i2c_fifo #(.AW(TX_AW)) u_tx_fifo (
        .clk      (clock_i),
        .srst     (reset_i),
        .push     (tx_wr_i),
        .push_dat (tx_dat_i),
        .pop      (m_newdat_i),
        .head     (tx_head),
        .head_nxt (tx_head_nxt),
        .level    (tx_level_o),
        .full     (tx_full_o),
        .empty    (tx_empty)
    );

    i2c_fifo #(.AW(RX_AW)) u_rx_fifo (
        .clk      (clock_i),
        .srst     (reset_i),
        .push     (m_dvalid_i),
        .push_dat (m_dat_i),
        .pop      (rx_rd_i),
        .head     (rx_dat_o),
        .head_nxt (rx_head_nxt_unused),
        .level    (rx_level_unused),
        .full     (rx_full),
        .empty    (rx_empty_o)
    );

    // The master latches dat_i on the edge that ends its newdat pulse, so the
    // byte behind the head must already be on the bus during that pulse.
    assign m_dat_o = m_newdat_i ? tx_head_nxt : tx_head;

    assign accept  = (state_reg == ST_IDLE) && cmd_valid_i;
    assign tx_need = (m_datnum_o > TX_DEPTH_L) ? TX_DEPTH_L : m_datnum_o;
    assign tx_ok   = (LEN_W'(tx_level_o) >= tx_need);

    assign nack_o   = nack_reg;
    assign tx_unf_o = unf_reg;
    assign rx_ovf_o = ovf_reg;

    always_comb begin
        state_next  = state_reg;
        cmd_ready_o = 1'b0;
        m_enable_o  = 1'b0;
        done_o      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) state_next = cmd_rw_i ? ST_LAUNCH : ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_ok) state_next = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                // Enable drops in the same cycle busy appears so the master cannot re-arm.
                if (m_busy_i) state_next = ST_RUN;
                else          m_enable_o = 1'b1;
            end
            ST_RUN: begin
                if (!m_busy_i) state_next = ST_DONE;
            end
            ST_DONE: begin
                done_o     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_reg    <= ST_IDLE;
            m_rw_o       <= 1'b0;
            m_ur_o       <= 1'b0;
            m_devadr_o   <= '0;
            m_regadr_o   <= '0;
            m_datnum_o   <= '0;
            byte_cnt_reg <= '0;
            nack_reg     <= 1'b0;
            unf_reg      <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                m_rw_o       <= cmd_rw_i;
                m_ur_o       <= cmd_ur_i;
                m_devadr_o   <= cmd_devadr_i;
                m_regadr_o   <= cmd_regadr_i;
                m_datnum_o   <= clamp_len(cmd_len_i);
                byte_cnt_reg <= '0;
                nack_reg     <= 1'b0;
                unf_reg      <= 1'b0;
                ovf_reg      <= 1'b0;
            end else begin
                byte_cnt_reg <= byte_cnt_reg + (LEN_W+1)'(m_newdat_i) + (LEN_W+1)'(m_dvalid_i);
                if (m_newdat_i && tx_empty)              unf_reg <= 1'b1;
                if (m_dvalid_i && rx_full && !rx_rd_i)   ovf_reg <= 1'b1;
                // Fewer bytes than requested means the slave cut the transfer short.
                if (state_reg == ST_DONE) nack_reg <= (byte_cnt_reg < {1'b0, m_datnum_o});
            end
        end
    end

endmodule

// File: tb/tb_i2c_xfer_ctrl.sv
// Self-checking bench: a behavioural master drives the controller while
// queue-based models predict FIFO contents, flags and completion status.
module tb_i2c_xfer_ctrl;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_rw_i;
    logic        cmd_ur_i;
    logic [6:0]  cmd_devadr_i;
    logic [7:0]  cmd_regadr_i;
    logic [15:0] cmd_len_i;
    logic        tx_wr_i;
    logic [7:0]  tx_dat_i;
    logic        tx_full_o;
    logic [4:0]  tx_level_o;
    logic        rx_rd_i;
    logic [7:0]  rx_dat_o;
    logic        rx_empty_o;
    logic        done_o;
    logic        nack_o;
    logic        tx_unf_o;
    logic        rx_ovf_o;
    logic        m_enable_o;
    logic        m_rw_o;
    logic        m_ur_o;
    logic [6:0]  m_devadr_o;
    logic [7:0]  m_regadr_o;
    logic [15:0] m_datnum_o;
    logic [7:0]  m_dat_o;
    logic [7:0]  m_dat_i;
    logic        m_busy_i;
    logic        m_dvalid_i;
    logic        m_newdat_i;

    always #5 clock_i = ~clock_i;

    i2c_xfer_ctrl dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_rw_i(cmd_rw_i), .cmd_ur_i(cmd_ur_i),
        .cmd_devadr_i(cmd_devadr_i), .cmd_regadr_i(cmd_regadr_i), .cmd_len_i(cmd_len_i),
        .tx_wr_i(tx_wr_i), .tx_dat_i(tx_dat_i), .tx_full_o(tx_full_o), .tx_level_o(tx_level_o),
        .rx_rd_i(rx_rd_i), .rx_dat_o(rx_dat_o), .rx_empty_o(rx_empty_o),
        .done_o(done_o), .nack_o(nack_o), .tx_unf_o(tx_unf_o), .rx_ovf_o(rx_ovf_o),
        .m_enable_o(m_enable_o), .m_rw_o(m_rw_o), .m_ur_o(m_ur_o),
        .m_devadr_o(m_devadr_o), .m_regadr_o(m_regadr_o), .m_datnum_o(m_datnum_o),
        .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
        .m_busy_i(m_busy_i), .m_dvalid_i(m_dvalid_i), .m_newdat_i(m_newdat_i)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       mdl_unf;
    logic       mdl_ovf;

    typedef struct {
        logic        rw;
        logic        ur;
        logic [6:0]  dev;
        logic [7:0]  rg;
        logic [15:0] len;
        int          push;
        int          acked;
        logic        exp_nack;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_tx(input int n, input int base);
        logic [7:0] d;
        for (int j = 0; j < n; j++) begin
            @(negedge clock_i);
            d = (base != 0) ? 8'(base + 'h11 * j) : 8'($urandom);
            tx_wr_i  = 1'b1;
            tx_dat_i = d;
            if (tx_q.size() < 16) tx_q.push_back(d);
        end
        @(negedge clock_i);
        tx_wr_i = 1'b0;
    endtask

    task automatic issue_cmd(input logic rw, input logic ur, input logic [6:0] dev,
                             input logic [7:0] rg, input logic [15:0] len);
        @(negedge clock_i);
        chk("cmd_ready_idle", cmd_ready_o, 1);
        cmd_valid_i  = 1'b1;
        cmd_rw_i     = rw;
        cmd_ur_i     = ur;
        cmd_devadr_i = dev;
        cmd_regadr_i = rg;
        cmd_len_i    = len;
        @(negedge clock_i);
        cmd_valid_i = 1'b0;
        mdl_unf = 1'b0;
        mdl_ovf = 1'b0;
        chk("cmd_ready_busy", cmd_ready_o, 0);
        chk("m_rw", m_rw_o, rw);
        chk("m_ur", m_ur_o, ur);
        chk("m_devadr", m_devadr_o, dev);
        chk("m_regadr", m_regadr_o, rg);
        chk("m_datnum", m_datnum_o, (len == 0) ? 16'd1 : len);
        chk("nack_clr", nack_o, 0);
        chk("flags_clr", {tx_unf_o, rx_ovf_o}, 0);
    endtask

    // Behavioural master: first write byte is taken when busy rises, each
    // newdat pulse takes the following one; reads deliver bytes via dvalid.
    task automatic run_master(input logic rw, input int acked, input logic exp_nack,
                              input int dbase, input string tag);
        int t;
        logic [7:0] d;
        t = 0;
        while (!m_enable_o && t < 64) begin
            @(negedge clock_i);
            t++;
        end
        chk("launch", m_enable_o, 1);
        m_busy_i = 1'b1;
        #1;
        chk("enable_drop", m_enable_o, 0);
        if (!rw && tx_q.size() > 0) chk("wdat_first", m_dat_o, tx_q[0]);
        for (int j = 0; j < acked; j++) begin
            @(negedge clock_i);
            @(negedge clock_i);
            if (!rw) begin
                m_newdat_i = 1'b1;
                #1;
                if (tx_q.size() >= 2) chk("wdat_next", m_dat_o, tx_q[1]);
                if (tx_q.size() > 0) void'(tx_q.pop_front());
                else mdl_unf = 1'b1;
            end else begin
                d = (dbase != 0) ? 8'(dbase * (j + 1)) : 8'($urandom);
                m_dat_i    = d;
                m_dvalid_i = 1'b1;
                if (rx_q.size() < 16) rx_q.push_back(d);
                else mdl_ovf = 1'b1;
            end
            @(negedge clock_i);
            m_newdat_i = 1'b0;
            m_dvalid_i = 1'b0;
        end
        @(negedge clock_i);
        @(negedge clock_i);
        m_busy_i = 1'b0;
        t = 0;
        while (t < 16) begin
            @(negedge clock_i);
            if (done_o) break;
            t++;
        end
        chk("done_pulse", done_o, 1);
        @(negedge clock_i);
        chk("done_one_cycle", done_o, 0);
        chk("nack", nack_o, exp_nack);
        chk("tx_unf", tx_unf_o, mdl_unf);
        chk("rx_ovf", rx_ovf_o, mdl_ovf);
        chk("tx_level", tx_level_o, tx_q.size());
        chk("rx_empty", rx_empty_o, rx_q.size() == 0);
        chk("cmd_ready_back", cmd_ready_o, 1);
        $display("xfer %s rw=%0d acked=%0d nack=%0d unf=%0d ovf=%0d", tag, rw, acked,
                 nack_o, tx_unf_o, rx_ovf_o);
    endtask

    task automatic drain_rx();
        while (rx_q.size() > 0) begin
            chk("rx_dat", rx_dat_o, rx_q.pop_front());
            rx_rd_i = 1'b1;
            @(negedge clock_i);
        end
        rx_rd_i = 1'b0;
        chk("rx_drained", rx_empty_o, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        rw;
        logic [15:0] len;
        int          acked;

        reset_i = 1'b1; cmd_valid_i = 1'b0; cmd_rw_i = 1'b0; cmd_ur_i = 1'b0;
        cmd_devadr_i = '0; cmd_regadr_i = '0; cmd_len_i = '0;
        tx_wr_i = 1'b0; tx_dat_i = '0; rx_rd_i = 1'b0;
        m_dat_i = '0; m_busy_i = 1'b0; m_dvalid_i = 1'b0; m_newdat_i = 1'b0;
        mdl_unf = 1'b0; mdl_ovf = 1'b0;

        //         rw    ur    dev     reg    len    push ack nack
        vecs[0] = '{1'b0, 1'b0, 7'h50, 8'h10, 16'd3,  3,  3,  1'b0};
        vecs[1] = '{1'b1, 1'b1, 7'h50, 8'h20, 16'd4,  0,  4,  1'b0};
        vecs[2] = '{1'b1, 1'b1, 7'h50, 8'h20, 16'd5,  0,  0,  1'b1};
        vecs[3] = '{1'b1, 1'b0, 7'h3a, 8'h00, 16'd20, 0,  20, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 7'h21, 8'h05, 16'd0,  1,  1,  1'b0};
        vecs[5] = '{1'b0, 1'b0, 7'h7f, 8'hff, 16'd16, 16, 16, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 7'h11, 8'h22, 16'd1,  1,  2,  1'b0};
        vecs[7] = '{1'b0, 1'b0, 7'h33, 8'h44, 16'd4,  4,  2,  1'b1};

        repeat (3) @(negedge clock_i);
        reset_i = 1'b0;
        @(negedge clock_i);
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_rx_empty", rx_empty_o, 1);
        chk("rst_tx_level", tx_level_o, 0);
        chk("rst_outputs", {done_o, nack_o, tx_unf_o, rx_ovf_o, m_enable_o, tx_full_o}, 0);
        chk("rst_m_fields", {m_rw_o, m_ur_o, m_devadr_o, m_regadr_o, m_datnum_o}, 0);

        for (int k = 0; k < 8; k++) begin
            if (vecs[k].push > 0) push_tx(vecs[k].push, (k == 0) ? 'hA1 : 0);
            chk("pre_tx_level", tx_level_o, tx_q.size());
            chk("pre_tx_full", tx_full_o, tx_q.size() == 16);
            issue_cmd(vecs[k].rw, vecs[k].ur, vecs[k].dev, vecs[k].rg, vecs[k].len);
            run_master(vecs[k].rw, vecs[k].acked, vecs[k].exp_nack, (k == 1) ? 'h11 : 0, "table");
            if (k == 3) chk("ovf_expected", rx_ovf_o, 1);
            drain_rx();
        end

        // Reset in the middle of a read.
        push_tx(3, 0);
        issue_cmd(1'b1, 1'b1, 7'h50, 8'h20, 16'd6);
        chk("mid_launch", m_enable_o, 1);
        m_busy_i = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clock_i);
            m_dat_i = 8'($urandom); m_dvalid_i = 1'b1;
            @(negedge clock_i);
            m_dvalid_i = 1'b0;
        end
        chk("mid_rx_has_data", rx_empty_o, 0);
        reset_i = 1'b1; m_busy_i = 1'b0;
        @(negedge clock_i);
        reset_i = 1'b0;
        tx_q.delete(); rx_q.delete(); mdl_unf = 1'b0; mdl_ovf = 1'b0;
        chk("mrst_tx_level", tx_level_o, 0);
        chk("mrst_rx_empty", rx_empty_o, 1);
        chk("mrst_cmd_ready", cmd_ready_o, 1);
        chk("mrst_outputs", {m_enable_o, done_o, nack_o, tx_unf_o, rx_ovf_o}, 0);
        push_tx(2, 0);
        issue_cmd(1'b0, 1'b0, 7'h12, 8'h34, 16'd2);
        run_master(1'b0, 2, 1'b0, 0, "post_reset");

        // Write held in WAIT_TX until enough bytes are buffered.
        push_tx(1, 0);
        issue_cmd(1'b0, 1'b0, 7'h2a, 8'h01, 16'd2);
        repeat (3) begin
            @(negedge clock_i);
            chk("hold_wait_tx", m_enable_o, 0);
        end
        tx_wr_i = 1'b1; tx_dat_i = 8'($urandom); tx_q.push_back(tx_dat_i);
        @(negedge clock_i);
        tx_wr_i = 1'b0;
        chk("hold_until_level", m_enable_o, 0);
        @(negedge clock_i);
        chk("launch_after_fill", m_enable_o, 1);
        run_master(1'b0, 2, 1'b0, 0, "wait_tx");

        // Randomized transactions against the queue model.
        for (int r = 0; r < 12; r++) begin
            rw    = 1'($urandom_range(0, 1));
            len   = 16'($urandom_range(1, 8));
            acked = $urandom_range(0, int'(len));
            if (!rw) push_tx(int'(len), 0);
            issue_cmd(rw, 1'($urandom), 7'($urandom), 8'($urandom), len);
            run_master(rw, acked, acked < int'(len), 0, "random");
            drain_rx();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
